// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the Mini-SRC control unit:
//   - instruction opcodes (OP_LD .. OP_HALT) taken from ir[31:27]
//   - ALU_ADD, the ALU operation used for address and offset adds
//   - MEM_TIMEOUT, the memory-wait limit used when CTRL_MEM_TIMEOUT_EN is defined
//   - state_t, the fetch/execute step encoding (T0..T7, HALT)
//   - instr_class_t, the groups of opcodes that share one step sequence
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BRX  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    localparam int MEM_TIMEOUT = 15;

    // T0..T7 are numbered so that state[2:0] is the step index.
    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU,     // add..rol: reg-reg ALU
        CL_IMM,     // addi/andi/ori
        CL_MULDIV,  // mul/div: 64-bit result to HI/LO
        CL_UNARY,   // neg/not
        CL_LD,
        CL_LDI,
        CL_ST,
        CL_BRX,
        CL_JR,
        CL_IN,
        CL_OUT,
        CL_MFHI,
        CL_MFLO,
        CL_NOP,     // nop and every undefined opcode
        CL_HALT
    } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Combinational opcode decode for the control unit.
// Ports:
//   op        in  5  instruction opcode, ir[31:27]
//   cls       out    instruction class selecting the execute step table
//   last_step out 3  index of the final step (2 = no execute steps)
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0]   op,
    output instr_class_t cls,
    output logic [2:0]   last_step
);

    always_comb begin
        cls       = CL_NOP;
        last_step = 3'd2;
        case (op) inside
            [OP_ADD:OP_ROL]: begin
                cls       = CL_ALU;
                last_step = 3'd5;
            end
            [OP_ADDI:OP_ORI]: begin
                cls       = CL_IMM;
                last_step = 3'd5;
            end
            OP_MUL, OP_DIV: begin
                cls       = CL_MULDIV;
                last_step = 3'd6;
            end
            OP_NEG, OP_NOT: begin
                cls       = CL_UNARY;
                last_step = 3'd4;
            end
            OP_LD: begin
                cls       = CL_LD;
                last_step = 3'd7;
            end
            OP_LDI: begin
                cls       = CL_LDI;
                last_step = 3'd5;
            end
            OP_ST: begin
                cls       = CL_ST;
                last_step = 3'd7;
            end
            OP_BRX: begin
                cls       = CL_BRX;
                last_step = 3'd6;
            end
            OP_JR: begin
                cls       = CL_JR;
                last_step = 3'd3;
            end
            OP_IN: begin
                cls       = CL_IN;
                last_step = 3'd3;
            end
            OP_OUT: begin
                cls       = CL_OUT;
                last_step = 3'd3;
            end
            OP_MFHI: begin
                cls       = CL_MFHI;
                last_step = 3'd3;
            end
            OP_MFLO: begin
                cls       = CL_MFLO;
                last_step = 3'd3;
            end
            OP_HALT: begin
                cls       = CL_HALT;
                last_step = 3'd2;
            end
            default: begin
                cls       = CL_NOP;
                last_step = 3'd2;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Moore FSM sequencing the Mini-SRC bus datapath through fetch (T0..T2) and
// execute (T3..T7). Outputs are decoded from the current state and ir[31:27].
//
// Memory handshake: in a memory step (T1, ld T6, st T7) Read/Write is held
// while mem_ready=0; mem_ready=1 in any cycle of the step advances on the
// next rising edge (mem_ready high on entry means no wait).
//
// Optional build macro CTRL_MEM_TIMEOUT_EN: a memory step that waits
// MEM_TIMEOUT cycles without mem_ready goes to HALT and sets the sticky
// fault flag. Without the macro the step waits forever and fault is 0.
//
// Ports:
//   clk, clr           clock, synchronous active-high reset
//   ir, con_in         IR contents and CON_FF result (status from datapath)
//   mem_ready, stop    memory completion, halt request at instruction boundary
//   *_out, Rout, BAout bus source selects (at most one per cycle)
//   *_enable           register loads
//   Read, Write, IncPC memory strobes and PC increment
//   Gra, Grb, Grc, Rin select-and-encode controls
//   opcode             ALU operation
//   run, fault         executing flag, sticky memory-timeout flag
//   dbg_state          current FSM state (state_t encoding)
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_in,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        PC_out,
    output logic        ZHigh_out,
    output logic        ZLow_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        In_port_out,
    output logic        C_out,
    output logic        MDR_out,
    output logic        MDR_enable,
    output logic        MAR_enable,
    output logic        Z_enable,
    output logic        Y_enable,
    output logic        IR_enable,
    output logic        PC_enable,
    output logic        CON_enable,
    output logic        LO_enable,
    output logic        HI_enable,
    output logic        OutPort_enable,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  opcode,
    output logic        run,
    output logic        fault,
    output logic [3:0]  dbg_state
);

    state_t       state_q;
    state_t       state_d;
    state_t       boundary;
    logic [4:0]   op;
    instr_class_t cls;
    logic [2:0]   last_step;
    logic         mem_step;
    logic         mem_hold;
    logic         timeout;
    logic         unused_ir;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[26:0];
    assign dbg_state = state_q;

    ctrl_decode u_decode (
        .op        (op),
        .cls       (cls),
        .last_step (last_step)
    );

    assign mem_step = (state_q == T1)
                   || (state_q == T6 && cls == CL_LD)
                   || (state_q == T7 && cls == CL_ST);
    assign mem_hold = mem_step && !mem_ready;

`ifdef CTRL_MEM_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       fault_q;

    assign timeout = mem_hold && (wait_cnt == 4'(MEM_TIMEOUT));
    assign fault   = fault_q;

    // Counts cycles spent waiting in the current memory step; any cycle
    // that is not a wait (including the timeout itself) clears it.
    always_ff @(posedge clk) begin
        if (clr) begin
            wait_cnt <= 4'd0;
            fault_q  <= 1'b0;
        end else begin
            if (mem_hold && !timeout) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
            if (timeout) begin
                fault_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign fault   = 1'b0;
`endif

    // State register and run flag.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= T0;
            run     <= 1'b1;
        end else begin
            state_q <= state_d;
            run     <= (state_d != HALT);
        end
    end

    // Next state. The '>=' guard returns to the boundary even if IR changes
    // under an instruction and the current step lies past its last step.
    always_comb begin
        state_d  = state_q;
        boundary = stop ? HALT : T0;
        case (state_q)
            T0:   state_d = T1;
            HALT: state_d = HALT;
            default: begin
                if (timeout) begin
                    state_d = HALT;
                end else if (mem_hold) begin
                    state_d = state_q;
                end else if (state_q == T2 && cls == CL_HALT) begin
                    state_d = HALT;
                end else if (state_q == T7 || state_q[2:0] >= last_step) begin
                    state_d = boundary;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
            end
        endcase
    end

    // Moore output decode; everything is 0 during clr and in HALT.
    always_comb begin
        PC_out         = 1'b0;
        ZHigh_out      = 1'b0;
        ZLow_out       = 1'b0;
        HI_out         = 1'b0;
        LO_out         = 1'b0;
        In_port_out    = 1'b0;
        C_out          = 1'b0;
        MDR_out        = 1'b0;
        MDR_enable     = 1'b0;
        MAR_enable     = 1'b0;
        Z_enable       = 1'b0;
        Y_enable       = 1'b0;
        IR_enable      = 1'b0;
        PC_enable      = 1'b0;
        CON_enable     = 1'b0;
        LO_enable      = 1'b0;
        HI_enable      = 1'b0;
        OutPort_enable = 1'b0;
        Read           = 1'b0;
        Write          = 1'b0;
        IncPC          = 1'b0;
        Gra            = 1'b0;
        Grb            = 1'b0;
        Grc            = 1'b0;
        Rin            = 1'b0;
        Rout           = 1'b0;
        BAout          = 1'b0;
        opcode         = 5'd0;
        if (!clr) begin
            case (state_q)
                T0: begin
                    PC_out     = 1'b1;
                    MAR_enable = 1'b1;
                    IncPC      = 1'b1;
                    PC_enable  = 1'b1;
                end
                T1: begin
                    Read       = 1'b1;
                    MDR_enable = 1'b1;
                end
                T2: begin
                    MDR_out   = 1'b1;
                    IR_enable = 1'b1;
                end
                T3: begin
                    case (cls)
                        CL_ALU, CL_IMM: begin
                            Grb = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
                        end
                        CL_MULDIV: begin
                            Gra = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
                        end
                        CL_UNARY: begin
                            Grb = 1'b1; Rout = 1'b1; opcode = op; Z_enable = 1'b1;
                        end
                        CL_LD, CL_LDI, CL_ST: begin
                            Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
                        end
                        CL_BRX: begin
                            Gra = 1'b1; Rout = 1'b1; CON_enable = 1'b1;
                        end
                        CL_JR: begin
                            Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1;
                        end
                        CL_IN: begin
                            In_port_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        CL_OUT: begin
                            Gra = 1'b1; Rout = 1'b1; OutPort_enable = 1'b1;
                        end
                        CL_MFHI: begin
                            HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        CL_MFLO: begin
                            LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    case (cls)
                        CL_ALU: begin
                            Grc = 1'b1; Rout = 1'b1; opcode = op; Z_enable = 1'b1;
                        end
                        CL_IMM: begin
                            C_out = 1'b1; opcode = op; Z_enable = 1'b1;
                        end
                        CL_MULDIV: begin
                            Grb = 1'b1; Rout = 1'b1; opcode = op; Z_enable = 1'b1;
                        end
                        CL_UNARY: begin
                            ZLow_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        CL_LD, CL_LDI, CL_ST: begin
                            C_out = 1'b1; opcode = ALU_ADD; Z_enable = 1'b1;
                        end
                        CL_BRX: begin
                            PC_out = 1'b1; Y_enable = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (cls)
                        CL_ALU, CL_IMM, CL_LDI: begin
                            ZLow_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        CL_MULDIV: begin
                            ZLow_out = 1'b1; LO_enable = 1'b1;
                        end
                        CL_LD, CL_ST: begin
                            ZLow_out = 1'b1; MAR_enable = 1'b1;
                        end
                        CL_BRX: begin
                            C_out = 1'b1; opcode = ALU_ADD; Z_enable = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (cls)
                        CL_MULDIV: begin
                            ZHigh_out = 1'b1; HI_enable = 1'b1;
                        end
                        CL_LD: begin
                            Read = 1'b1; MDR_enable = 1'b1;
                        end
                        CL_ST: begin
                            Gra = 1'b1; Rout = 1'b1; MDR_enable = 1'b1;
                        end
                        CL_BRX: begin
                            // Branch taken only when CON_FF is set.
                            ZLow_out  = con_in;
                            PC_enable = con_in;
                        end
                        default: ;
                    endcase
                end
                T7: begin
                    case (cls)
                        CL_LD: begin
                            MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        CL_ST: begin
                            Write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Directed bench for control_unit. Each cycle of a stimulus sequence pushes
// the inputs to apply ({stop, con_in, mem_ready}) and the expected word
// {fault, run, state, opcode, control bits}; run_queue applies and compares.
module tb_control_unit;

    localparam int W = 38;

    // Control bit positions in ctl_vec.
    localparam logic [26:0] B_PC_OUT  = 27'd1 << 0;
    localparam logic [26:0] B_ZHI_OUT = 27'd1 << 1;
    localparam logic [26:0] B_ZLO_OUT = 27'd1 << 2;
    localparam logic [26:0] B_HI_OUT  = 27'd1 << 3;
    localparam logic [26:0] B_LO_OUT  = 27'd1 << 4;
    localparam logic [26:0] B_IN_OUT  = 27'd1 << 5;
    localparam logic [26:0] B_C_OUT   = 27'd1 << 6;
    localparam logic [26:0] B_MDR_OUT = 27'd1 << 7;
    localparam logic [26:0] B_MDR_EN  = 27'd1 << 8;
    localparam logic [26:0] B_MAR_EN  = 27'd1 << 9;
    localparam logic [26:0] B_Z_EN    = 27'd1 << 10;
    localparam logic [26:0] B_Y_EN    = 27'd1 << 11;
    localparam logic [26:0] B_IR_EN   = 27'd1 << 12;
    localparam logic [26:0] B_PC_EN   = 27'd1 << 13;
    localparam logic [26:0] B_CON_EN  = 27'd1 << 14;
    localparam logic [26:0] B_LO_EN   = 27'd1 << 15;
    localparam logic [26:0] B_HI_EN   = 27'd1 << 16;
    localparam logic [26:0] B_OUTP_EN = 27'd1 << 17;
    localparam logic [26:0] B_READ    = 27'd1 << 18;
    localparam logic [26:0] B_WRITE   = 27'd1 << 19;
    localparam logic [26:0] B_INCPC   = 27'd1 << 20;
    localparam logic [26:0] B_GRA     = 27'd1 << 21;
    localparam logic [26:0] B_GRB     = 27'd1 << 22;
    localparam logic [26:0] B_GRC     = 27'd1 << 23;
    localparam logic [26:0] B_RIN     = 27'd1 << 24;
    localparam logic [26:0] B_ROUT    = 27'd1 << 25;
    localparam logic [26:0] B_BAOUT   = 27'd1 << 26;
    localparam logic [26:0] SRC_MASK  = 27'h600_00FF;

    // Drive patterns {stop, con_in, mem_ready}.
    localparam logic [2:0] D_MR   = 3'b001;
    localparam logic [2:0] D_WAIT = 3'b000;
    localparam logic [2:0] D_CON  = 3'b011;
    localparam logic [2:0] D_STOP = 3'b101;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr = 1'b1;
    logic [31:0] ir = 32'd0;
    logic        con_in = 1'b0;
    logic        mem_ready = 1'b0;
    logic        stop = 1'b0;

    logic PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out, MDR_out;
    logic MDR_enable, MAR_enable, Z_enable, Y_enable, IR_enable, PC_enable, CON_enable;
    logic LO_enable, HI_enable, OutPort_enable, Read, Write, IncPC;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0] opcode;
    logic run, fault;
    logic [3:0] dbg_state;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_in(con_in), .mem_ready(mem_ready), .stop(stop),
        .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out), .HI_out(HI_out),
        .LO_out(LO_out), .In_port_out(In_port_out), .C_out(C_out), .MDR_out(MDR_out),
        .MDR_enable(MDR_enable), .MAR_enable(MAR_enable), .Z_enable(Z_enable),
        .Y_enable(Y_enable), .IR_enable(IR_enable), .PC_enable(PC_enable),
        .CON_enable(CON_enable), .LO_enable(LO_enable), .HI_enable(HI_enable),
        .OutPort_enable(OutPort_enable), .Read(Read), .Write(Write), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .opcode(opcode), .run(run), .fault(fault), .dbg_state(dbg_state)
    );

    logic [26:0]  ctl_vec;
    logic [W-1:0] obs;
    assign ctl_vec = {BAout, Rout, Rin, Grc, Grb, Gra, IncPC, Write, Read, OutPort_enable,
                      HI_enable, LO_enable, CON_enable, PC_enable, IR_enable, Y_enable,
                      Z_enable, MAR_enable, MDR_enable, MDR_out, C_out, In_port_out,
                      LO_out, HI_out, ZLow_out, ZHigh_out, PC_out};
    assign obs = {fault, run, dbg_state, opcode, ctl_vec};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [2:0]   drv_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int bus_viol = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    always @(negedge clk) begin
        if ($countones(ctl_vec & SRC_MASK) > 1) bus_viol++;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] mk_ir(input logic [4:0] op);
        return {op, 4'd1, 4'd2, 4'd3, 15'd4};
    endfunction

    task automatic push(input logic [2:0] d, input logic [3:0] st,
                        input logic [4:0] opc, input logic [26:0] ctl);
        drv_q.push_back(d);
        exp_q.push_back({1'b0, 1'b1, st, opc, ctl});
    endtask

    task automatic push_halt(input logic [2:0] d, input logic flt);
        drv_q.push_back(d);
        exp_q.push_back({flt, 1'b0, 4'd8, 5'd0, 27'd0});
    endtask

    task automatic push_fetch(input int t1_waits);
        push(D_MR, 4'd0, 5'd0, B_PC_OUT | B_MAR_EN | B_INCPC | B_PC_EN);
        for (int i = 0; i < t1_waits; i++) push(D_WAIT, 4'd1, 5'd0, B_READ | B_MDR_EN);
        push(D_MR, 4'd1, 5'd0, B_READ | B_MDR_EN);
        push(D_MR, 4'd2, 5'd0, B_MDR_OUT | B_IR_EN);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_queue(input string name);
        logic [W-1:0] e;
        logic [2:0]   d;
        int cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = drv_q.pop_front();
            {stop, con_in, mem_ready} = d;
            #1;
            check($sformatf("%s_c%0d", name, cyc), 64'(obs), 64'(e));
            cyc++;
            @(posedge clk);
            #1;
        end
        {stop, con_in, mem_ready} = D_MR;
    endtask

    task automatic do_clr(input string name);
        clr = 1'b1;
        #1;
        check({name, "_ctl_in_clr"}, 64'({opcode, ctl_vec}), 64'd0);
        @(posedge clk);
        #1;
        check({name, "_after_clr"}, 64'({fault, run, dbg_state, opcode, ctl_vec}),
              64'({1'b0, 1'b1, 4'd0, 5'd0, 27'd0}));
        clr = 1'b0;
    endtask

    localparam logic [26:0] ADDR_T3 = B_GRB | B_BAOUT | B_Y_EN;
    localparam logic [26:0] ADDR_T4 = B_C_OUT | B_Z_EN;

    // ---------------- stimulus ----------------
    initial begin
        // Reset, two cycles.
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ctl", 64'({opcode, ctl_vec}), 64'd0);
        @(posedge clk);
        #1;
        check("reset_state", 64'({fault, run, dbg_state}), 64'({1'b0, 1'b1, 4'd0}));
        clr = 1'b0;

        // add r1,r2,r3
        ir = mk_ir(5'b00011);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0,      B_GRB | B_ROUT | B_Y_EN);
        push(D_MR, 4'd4, 5'b00011,  B_GRC | B_ROUT | B_Z_EN);
        push(D_MR, 4'd5, 5'd0,      B_ZLO_OUT | B_GRA | B_RIN);
        run_queue("add");

        // ld r1,4(r2) with three wait cycles at T6
        ir = mk_ir(5'b00000);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0, ADDR_T3);
        push(D_MR, 4'd4, 5'b00011, ADDR_T4);
        push(D_MR, 4'd5, 5'd0, B_ZLO_OUT | B_MAR_EN);
        for (int i = 0; i < 3; i++) push(D_WAIT, 4'd6, 5'd0, B_READ | B_MDR_EN);
        push(D_MR, 4'd6, 5'd0, B_READ | B_MDR_EN);
        push(D_MR, 4'd7, 5'd0, B_MDR_OUT | B_GRA | B_RIN);
        run_queue("ld");

        // st with two fetch wait cycles and one write wait cycle
        ir = mk_ir(5'b00010);
        push_fetch(2);
        push(D_MR, 4'd3, 5'd0, ADDR_T3);
        push(D_MR, 4'd4, 5'b00011, ADDR_T4);
        push(D_MR, 4'd5, 5'd0, B_ZLO_OUT | B_MAR_EN);
        push(D_MR, 4'd6, 5'd0, B_GRA | B_ROUT | B_MDR_EN);
        push(D_WAIT, 4'd7, 5'd0, B_WRITE);
        push(D_MR, 4'd7, 5'd0, B_WRITE);
        run_queue("st");

        // ldi
        ir = mk_ir(5'b00001);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0, ADDR_T3);
        push(D_MR, 4'd4, 5'b00011, ADDR_T4);
        push(D_MR, 4'd5, 5'd0, B_ZLO_OUT | B_GRA | B_RIN);
        run_queue("ldi");

        // brx, condition false then true
        for (int c = 0; c < 2; c++) begin
            ir = mk_ir(5'b10011);
            push_fetch(0);
            push(D_MR, 4'd3, 5'd0, B_GRA | B_ROUT | B_CON_EN);
            push(D_MR, 4'd4, 5'd0, B_PC_OUT | B_Y_EN);
            push(D_MR, 4'd5, 5'b00011, B_C_OUT | B_Z_EN);
            if (c == 0) push(D_MR, 4'd6, 5'd0, 27'd0);
            else        push(D_CON, 4'd6, 5'd0, B_ZLO_OUT | B_PC_EN);
            run_queue(c == 0 ? "brx_nt" : "brx_t");
        end

        // mul
        ir = mk_ir(5'b01111);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0, B_GRA | B_ROUT | B_Y_EN);
        push(D_MR, 4'd4, 5'b01111, B_GRB | B_ROUT | B_Z_EN);
        push(D_MR, 4'd5, 5'd0, B_ZLO_OUT | B_LO_EN);
        push(D_MR, 4'd6, 5'd0, B_ZHI_OUT | B_HI_EN);
        run_queue("mul");

        // ori
        ir = mk_ir(5'b01110);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0, B_GRB | B_ROUT | B_Y_EN);
        push(D_MR, 4'd4, 5'b01110, B_C_OUT | B_Z_EN);
        push(D_MR, 4'd5, 5'd0, B_ZLO_OUT | B_GRA | B_RIN);
        run_queue("ori");

        // not
        ir = mk_ir(5'b10010);
        push_fetch(0);
        push(D_MR, 4'd3, 5'b10010, B_GRB | B_ROUT | B_Z_EN);
        push(D_MR, 4'd4, 5'd0, B_ZLO_OUT | B_GRA | B_RIN);
        run_queue("not");

        // single-step execute ops
        ir = mk_ir(5'b10100);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0, B_GRA | B_ROUT | B_PC_EN);
        run_queue("jr");
        ir = mk_ir(5'b10110);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0, B_IN_OUT | B_GRA | B_RIN);
        run_queue("in");
        ir = mk_ir(5'b10111);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0, B_GRA | B_ROUT | B_OUTP_EN);
        run_queue("out");
        ir = mk_ir(5'b11000);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0, B_HI_OUT | B_GRA | B_RIN);
        run_queue("mfhi");
        ir = mk_ir(5'b11001);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0, B_LO_OUT | B_GRA | B_RIN);
        run_queue("mflo");

        // nop and an undefined op return from T2 to T0
        ir = mk_ir(5'b11010);
        push_fetch(0);
        run_queue("nop");
        ir = mk_ir(5'b10101);
        push_fetch(0);
        run_queue("undef");

        // stop raised during the last step of add -> HALT, clr recovers
        ir = mk_ir(5'b00011);
        push_fetch(0);
        push(D_MR, 4'd3, 5'd0, B_GRB | B_ROUT | B_Y_EN);
        push(D_MR, 4'd4, 5'b00011, B_GRC | B_ROUT | B_Z_EN);
        push(D_STOP, 4'd5, 5'd0, B_ZLO_OUT | B_GRA | B_RIN);
        push_halt(D_MR, 1'b0);
        push_halt(D_MR, 1'b0);
        run_queue("stop_add");
        do_clr("stop");

        // halt op -> HALT after T2, clr recovers
        ir = mk_ir(5'b11011);
        push_fetch(0);
        push_halt(D_MR, 1'b0);
        push_halt(D_MR, 1'b0);
        run_queue("halt_op");
        do_clr("halt");

`ifdef CTRL_MEM_TIMEOUT_EN
        // mem_ready never arrives in T1: 15 counted waits, then HALT with fault
        ir = mk_ir(5'b00011);
        push(D_WAIT, 4'd0, 5'd0, B_PC_OUT | B_MAR_EN | B_INCPC | B_PC_EN);
        for (int i = 0; i < 16; i++) push(D_WAIT, 4'd1, 5'd0, B_READ | B_MDR_EN);
        push_halt(D_WAIT, 1'b1);
        push_halt(D_WAIT, 1'b1);
        run_queue("timeout");
        do_clr("timeout");
`endif

        // after recovery, a normal instruction still runs
        ir = mk_ir(5'b10001);
        push_fetch(0);
        push(D_MR, 4'd3, 5'b10001, B_GRB | B_ROUT | B_Z_EN);
        push(D_MR, 4'd4, 5'd0, B_ZLO_OUT | B_GRA | B_RIN);
        push(D_MR, 4'd0, 5'd0, B_PC_OUT | B_MAR_EN | B_INCPC | B_PC_EN);
        run_queue("neg");

        check("bus_exclusive", 64'(bus_viol), 64'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Moore FSM that sequences the 32-bit bus datapath through fetch and execute for the Mini-SRC instruction set. It drives every bus-source select, register enable, ALU opcode and memory strobe, and stalls on a memory ready handshake. It sits beside the datapath and its select-and-encode logic, and takes IR and CON_FF back as status.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory step waits for mem_ready (used only with CTRL_MEM_TIMEOUT_EN).
ALU_ADD, 5'b00011, ALU opcode driven for address/offset adds.

Ports:
clk  in  1  clock; all state changes on rising edge.
clr  in  1  synchronous active-high reset.
ir  in  32  IR contents; op=ir[31:27].
con_in  in  1  CON_FF branch-condition result.
mem_ready  in  1  memory completes the current Read/Write this cycle.
stop  in  1  request halt at next instruction boundary.
PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out, MDR_out  out  1 each  bus source selects.
MDR_enable, MAR_enable, Z_enable, Y_enable, IR_enable, PC_enable, CON_enable, LO_enable, HI_enable, OutPort_enable  out  1 each  register loads.
Read, Write, IncPC  out  1 each  memory strobes / PC increment.
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  to select-and-encode.
opcode  out  5  ALU operation.
run  out  1  1 = executing; 0 = halted.
fault  out  1  memory timeout occurred (sticky).

Behaviour:
- States: T0..T7, HALT. Outputs decode from state + op only, never from next-state.
- clr=1: next state T0, run<=1, fault<=0, timeout counter<=0. All control outputs forced 0 while clr=1.
- The first cycle after clr falls is T0.
- At most one bus source is active per cycle: the *_out signals, Rout, BAout. This is a checkable invariant.
- Fetch:
  - T0: PC_out, MAR_enable, IncPC, PC_enable.
  - T1: Read, MDR_enable; hold until mem_ready.
  - T2: MDR_out, IR_enable.
- Execute, by op. Default opcode=0 unless stated.
  - add..rol, 00011-01011:
    - T3: Grb, Rout, Y_enable.
    - T4: Grc, Rout, opcode=op, Z_enable.
    - T5: ZLow_out, Gra, Rin.
  - addi/andi/ori, 01100-01110:
    - T3: Grb, Rout, Y_enable.
    - T4: C_out, opcode=op, Z_enable.
    - T5: ZLow_out, Gra, Rin.
  - mul/div, 01111/10000:
    - T3: Gra, Rout, Y_enable.
    - T4: Grb, Rout, opcode=op, Z_enable.
    - T5: ZLow_out, LO_enable.
    - T6: ZHigh_out, HI_enable.
  - neg/not, 10001/10010:
    - T3: Grb, Rout, opcode=op, Z_enable.
    - T4: ZLow_out, Gra, Rin.
  - ld/ldi/st, 00000/00001/00010:
    - T3: Grb, BAout, Y_enable.
    - T4: C_out, opcode=ALU_ADD, Z_enable.
    - ldi T5: ZLow_out, Gra, Rin.
    - ld/st T5: ZLow_out, MAR_enable.
    - ld T6: Read, MDR_enable (wait). ld T7: MDR_out, Gra, Rin.
    - st T6: Gra, Rout, MDR_enable. st T7: Write (wait).
  - brx, 10011:
    - T3: Gra, Rout, CON_enable.
    - T4: PC_out, Y_enable.
    - T5: C_out, opcode=ALU_ADD, Z_enable.
    - T6: if con_in, ZLow_out and PC_enable; else no enables.
  - jr, 10100: T3: Gra, Rout, PC_enable.
  - in, 10110: T3: In_port_out, Gra, Rin.
  - out, 10111: T3: Gra, Rout, OutPort_enable.
  - mfhi/mflo, 11000/11001: T3: HI_out/LO_out, Gra, Rin.
  - nop 11010 and undefined ops: T2 -> T0.
  - halt 11011: T2 -> HALT.
- After the last execute step, next state is T0. If stop=1 when moving into T0, go to HALT instead.
- HALT: run=0, all controls 0, exit only via clr.
- Memory wait (T1, ld T6, st T7):
  - While mem_ready=0, hold state and outputs.
  - mem_ready=1 advances next edge.
  - mem_ready high on entry gives zero wait.
- clr mid-instruction aborts immediately; no partial writes after the clr edge.

Optional Feature:
CTRL_MEM_TIMEOUT_EN
- Defined:
  - A 4-bit counter counts cycles held in a memory step.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, next state is HALT and fault<=1.
  - Counter clears on leaving the step.
- Undefined: wait forever; fault tied 0; no counter.

Decomposition:
- ctrl_pkg: opcode constants OP_LD..OP_HALT, state encoding T0..T7/HALT, ALU_ADD, instruction-class enum.
- One sub-module ctrl_decode: combinational op -> class and last-step index. This keeps the FSM step table separate from opcode decode.

Test Plan:
- clr 2 cycles, then ir=add r1,r2,r3, mem_ready=1 -> T0..T5 in 6 cycles; T4 opcode=00011 with Grc and Rout; T5 ZLow_out with Gra and Rin; back to T0.
- ld r1,4(r2), mem_ready low 3 cycles at T6 -> Read/MDR_enable held 4 cycles; T7 MDR_out with Rin; T4 opcode=00011.
- brx: con_in=0 -> T6 PC_enable=0; con_in=1 -> T6 ZLow_out with PC_enable=1.
- mul -> T5 LO_enable, T6 HI_enable; never both sources in one cycle (assertion across all ops).
- halt op and stop=1 mid-add -> HALT after T2 / after T5 respectively; run=0; clr recovers to T0.
- CTRL_MEM_TIMEOUT_EN, mem_ready=0 at T1 -> HALT with fault=1 after 15 wait cycles; clr clears fault.
